// File: rtl/mem_access_unit.sv
// Initiator for a 32-bit little-endian data memory with a combinational read port.
// Loads take 2 cycles and errors 1. Word stores take 2 cycles. Sub-word stores take 3 (read-modify-write). req_ready is high only in IDLE.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wrdata,
  input  logic [31:0]       mem_rddata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [1:0]          lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wrdata_q, wrdata_d;
  logic                bad_req;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the word just read back.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] size,
                                        input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (size == 2'b00) r[{lane, 3'b000} +: 8] = wd[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'h0;
    err_d        = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          ready_d = 1'b0;
          if (bad_req) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
          end else if (req_we && req_size == 2'b10) begin
            state_d     = S_WR;
            mem_write_d = 1'b1;
            wrdata_d    = req_wdata;
          end else begin
            state_d    = S_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d     = S_WR;
          mem_write_d = 1'b1;
          wrdata_d    = merge(mem_rddata, size_q, lane_q, wdata_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = extract(mem_rddata, size_q, lane_q, sgn_q);
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = addr_q;
  assign mem_wrdata = wrdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-array memory and reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AW = 10;
  localparam int MB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid, resp_err, mem_read, mem_write;
  logic [31:0]   resp_rdata, mem_wrdata, mem_rddata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
  );

  logic [7:0] mem_b [MB];
  logic [7:0] ref_b [MB];

  // Memory returns 0 whenever both strobes collide.
  assign mem_rddata = (mem_read && !mem_write) ?
      {mem_b[int'(mem_addr)+3], mem_b[int'(mem_addr)+2], mem_b[int'(mem_addr)+1], mem_b[int'(mem_addr)]} : 32'h0;

  always @(posedge clk)
    if (mem_write && !mem_read)
      for (int i = 0; i < 4; i++) mem_b[int'(mem_addr)+i] <= mem_wrdata[8*i +: 8];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: bytes addressed directly; sizes are 1, 2 or 4 bytes.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [AW-1:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          a, nb;
    logic [31:0] v;
    a = int'(addr);
    e.acc = 0;
    e.rdata = 32'h0;
    e.err = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    nb = 1 << size;
    if (we) begin
      for (int i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
      e.lat = (nb == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[a+i];
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      e.rdata = v;
      e.lat = 2;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("strobe_conflict", {31'h0, mem_read & mem_write}, 32'h0);
      if (mem_read || mem_write) chk("mem_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (resp_valid) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got=resp_valid want=none (t=%0t)", $time);
        end else begin
          e = expq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] addr, input logic [31:0] wd,
                       input bit want_resp, output int acc);
    exp_t e;
    int   n;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_timeout: got=req_ready 0 want=1 (t=%0t)", $time);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    e = model(we, size, sgn, addr, wd);
    e.acc = acc;
    if (want_resp) expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  int acc, prev;
  int n;

  initial begin
    for (int i = 0; i < MB; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst_mem_wrdata", mem_wrdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // Word store then word load.
    issue(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 1, acc);
    issue(0, 2'd2, 0, 10'h010, 32'h0, 1, acc);
    chk("mem_bytes_0x10", {mem_b[19], mem_b[18], mem_b[17], mem_b[16]}, 32'hDEADBEEF);

    // Byte store 0x5A @0x012: read then merged write.
    issue(1, 2'd0, 0, 10'h012, 32'h0000005A, 1, acc);
    chk("rmw_rd_strobe", {31'h0, mem_read}, 32'h1);
    chk("rmw_rd_addr", {22'h0, mem_addr}, 32'h010);
    @(negedge clk);
    chk("rmw_wr_strobe", {31'h0, mem_write}, 32'h1);
    chk("rmw_wrdata", mem_wrdata, 32'hDE5ABEEF);
    chk("rmw_wr_addr", {22'h0, mem_addr}, 32'h010);

    // Sign/zero extension.
    issue(0, 2'd0, 1, 10'h013, 32'h0, 1, acc);
    issue(0, 2'd0, 0, 10'h013, 32'h0, 1, acc);
    issue(0, 2'd1, 1, 10'h010, 32'h0, 1, acc);

    // Misaligned and illegal size: no memory strobes.
    issue(0, 2'd1, 0, 10'h011, 32'h0, 1, acc);
    chk("err_half_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    issue(1, 2'd2, 0, 10'h012, 32'h12345678, 1, acc);
    chk("err_word_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    issue(1, 2'd3, 0, 10'h014, 32'h12345678, 1, acc);
    chk("err_size_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);

    // Back-to-back loads, request held valid.
    issue(0, 2'd2, 0, 10'h010, 32'h0, 1, prev);
    for (int i = 1; i < 4; i++) begin
      issue(0, 2'd0, i[0], 10'(16 + i), 32'h0, 1, acc);
      chk("b2b_spacing", acc - prev, 3);
      prev = acc;
    end

    // Top address byte ops.
    issue(1, 2'd0, 0, 10'h3FF, 32'hFFFFFFA5, 1, acc);
    issue(0, 2'd0, 1, 10'h3FF, 32'h0, 1, acc);
    issue(0, 2'd1, 0, 10'h3FE, 32'h0, 1, acc);

    // Reset during the WR cycle of a half store: write commits, no response.
    issue(1, 2'd1, 0, 10'h022, 32'h0000C3D4, 0, acc);
    @(negedge clk);
    chk("rst_mid_in_wr", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_resp", {31'h0, resp_valid}, 32'h0);
    chk("rst_mid_no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mid_ready_low", {31'h0, req_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_high", {31'h0, req_ready}, 32'h1);
    issue(0, 2'd2, 0, 10'h020, 32'h0, 1, acc);

    // Random mix.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), AW'($urandom), $urandom, 1, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", expq.size(), 0);
    for (int w = 0; w < MB; w += 4)
      chk("mem_contents", {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]},
          {ref_b[w+3], ref_b[w+2], ref_b[w+1], ref_b[w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
